cell_pos_dbuf: RTL and testbench

- Parametrised, double-buffered successor to the per-cell particle position memory.
- Holds two banks of {posz, posy, posx} records.
  - Active bank: serves force-evaluation reads with a fixed 2-cycle latency.
  - Shadow bank: filled by the motion-update unit in append order.
- A single-cycle swap exchanges the banks, so a timestep boundary needs no copy.
- One instance sits under each cell's position cache in place of the single-port cell memory.

---
 rtl/cell_pos_dbuf_if.sv | 32 +++
 rtl/cell_pos_dbuf.sv | 109 ++++++++++
 tb/tb_cell_pos_dbuf.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/cell_pos_dbuf_if.sv
// cell_pos_dbuf_if: read, append and swap signals of the
// double-buffered per-cell position memory.
interface cell_pos_dbuf_if #(
    parameter int DATA_WIDTH = 96,
    parameter int ADDR_WIDTH = 8
);
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  wr_start;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_full;
    logic                  wr_overflow;
    logic                  swap;
    logic                  bank_sel;
    logic [ADDR_WIDTH-1:0] active_count;
    logic [ADDR_WIDTH-1:0] shadow_count;

    modport master (
        output rd_en, rd_addr, wr_start, wr_en, wr_data, swap,
        input  rd_data, rd_valid, wr_full, wr_overflow,
        input  bank_sel, active_count, shadow_count
    );

    modport slave (
        input  rd_en, rd_addr, wr_start, wr_en, wr_data, swap,
        output rd_data, rd_valid, wr_full, wr_overflow,
        output bank_sel, active_count, shadow_count
    );
endinterface

// File: rtl/cell_pos_dbuf.sv
// cell_pos_dbuf: two-bank particle position store; the active bank
// serves 2-cycle reads while the shadow bank is appended, swap flips them.
module cell_pos_dbuf #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic            clock,
    input  logic            rst_n,
    cell_pos_dbuf_if.slave  bus
);
    localparam int DEPTH = 2 ** (ADDR_WIDTH + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(PARTICLE_NUM - 1);

    typedef struct packed {
        logic                  valid;
        logic                  bank;
        logic [ADDR_WIDTH-1:0] addr;
        logic [ADDR_WIDTH-1:0] count;
    } rd_s1_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  bank_sel;
    logic [ADDR_WIDTH-1:0] active_count;
    logic [ADDR_WIDTH-1:0] shadow_count;
    logic                  wr_overflow;
    rd_s1_t                s1;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;

    logic [ADDR_WIDTH-1:0] fill_base;
    logic                  base_full;
    logic                  do_wr;
    logic [ADDR_WIDTH:0]   wr_idx;
    logic                  hit;
    logic [DATA_WIDTH-1:0] rd_word;

    // Effective fill point: wr_start clears it unless swap wins this cycle.
    always_comb begin
        fill_base = shadow_count;
        if (bus.wr_start && !bus.swap)
            fill_base = '0;
        base_full = (fill_base == LAST);
        do_wr     = bus.wr_en && !base_full;
        wr_idx    = {~bank_sel, fill_base + ADDR_WIDTH'(1)};
    end

    // Bank select, counts and sticky overflow.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            bank_sel     <= 1'b0;
            active_count <= '0;
            shadow_count <= '0;
            wr_overflow  <= 1'b0;
        end else if (bus.swap) begin
            bank_sel     <= ~bank_sel;
            active_count <= shadow_count + ADDR_WIDTH'(do_wr);
            shadow_count <= '0;
            wr_overflow  <= 1'b0;
        end else begin
            shadow_count <= fill_base + ADDR_WIDTH'(do_wr);
            wr_overflow  <= (bus.wr_start ? 1'b0 : wr_overflow)
                          | (bus.wr_en & base_full);
        end
    end

    // Shadow bank append port; contents need no reset.
    always_ff @(posedge clock) begin
        if (do_wr)
            mem[wr_idx] <= bus.wr_data;
    end

    // Gate the stage-1 read with the count sampled alongside it.
    always_comb begin
        hit     = (s1.addr != '0) && (s1.addr <= s1.count)
                  && (s1.addr <= LAST);
        rd_word = '0;
        if (s1.addr == '0)
            rd_word = {{(DATA_WIDTH - ADDR_WIDTH){1'b0}}, s1.count};
        else if (hit)
            rd_word = mem[{s1.bank, s1.addr}];
    end

    // Read pipeline: stage 1 captures request, stage 2 the data.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            s1.valid <= bus.rd_en;
            s1.bank  <= bank_sel;
            s1.addr  <= bus.rd_addr;
            s1.count <= active_count;
            rd_valid <= s1.valid;
            if (s1.valid)
                rd_data <= rd_word;
        end
    end

    assign bus.rd_data      = rd_data;
    assign bus.rd_valid     = rd_valid;
    assign bus.wr_full      = (shadow_count == LAST);
    assign bus.wr_overflow  = wr_overflow;
    assign bus.bank_sel     = bank_sel;
    assign bus.active_count = active_count;
    assign bus.shadow_count = shadow_count;
endmodule

// File: tb/tb_cell_pos_dbuf.sv
// tb_cell_pos_dbuf: directed checks of the double-buffered position
// memory, plus a PARTICLE_NUM=4 instance for the full/overflow edge.
module tb_cell_pos_dbuf;
    logic clock = 1'b0;
    logic rst_n = 1'b0;

    always #5 clock = ~clock;

    cell_pos_dbuf_if #(.DATA_WIDTH(96), .ADDR_WIDTH(8)) bus ();
    cell_pos_dbuf_if #(.DATA_WIDTH(96), .ADDR_WIDTH(3)) sbus ();

    cell_pos_dbuf #(
        .DATA_WIDTH(96), .PARTICLE_NUM(220), .ADDR_WIDTH(8)
    ) u_dut (
        .clock(clock), .rst_n(rst_n), .bus(bus.slave)
    );

    cell_pos_dbuf #(
        .DATA_WIDTH(96), .PARTICLE_NUM(4), .ADDR_WIDTH(3)
    ) u_small (
        .clock(clock), .rst_n(rst_n), .bus(sbus.slave)
    );

    localparam logic [95:0] A = 96'h00000001_00000002_00000003;
    localparam logic [95:0] B = 96'h00000011_00000012_00000013;
    localparam logic [95:0] C = 96'h00000021_00000022_00000023;
    localparam logic [95:0] D = 96'h3f800000_40000000_40400000;
    localparam logic [95:0] E = 96'hbf800000_c0000000_c0400000;
    localparam logic [95:0] F = 96'hdeadbeef_cafef00d_12345678;
    localparam logic [95:0] Z = 96'h0;

    int errs   = 0;
    int checks = 0;

    logic        prev_v;
    logic [95:0] prev_d;
    logic [95:0] last_d;

    task automatic check(input string tag,
                         input logic [95:0] obs,
                         input logic [95:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle on the big instance, then check the read issued
    // one step earlier (it lands 2 edges after its own issue).
    task automatic step(input logic ws, input logic we,
                        input logic [95:0] wd, input logic sw,
                        input logic re, input logic [7:0] ra,
                        input logic [95:0] rx);
        bus.wr_start = ws;
        bus.wr_en    = we;
        bus.wr_data  = wd;
        bus.swap     = sw;
        bus.rd_en    = re;
        bus.rd_addr  = ra;
        @(posedge clock);
        #1;
        check("rd_valid", {95'b0, bus.rd_valid}, {95'b0, prev_v});
        if (prev_v) begin
            check("rd_data", bus.rd_data, prev_d);
            last_d = prev_d;
        end else begin
            check("rd_hold", bus.rd_data, last_d);
        end
        prev_v = re;
        prev_d = rx;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, Z, 1'b0, 1'b0, 8'd0, Z);
    endtask

    task automatic rd(input logic [7:0] ra, input logic [95:0] rx);
        step(1'b0, 1'b0, Z, 1'b0, 1'b1, ra, rx);
    endtask

    task automatic app(input logic [95:0] wd);
        step(1'b0, 1'b1, wd, 1'b0, 1'b0, 8'd0, Z);
    endtask

    initial begin
        bus.wr_start  = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_data   = '0;
        bus.swap      = 1'b0;
        bus.rd_en     = 1'b0;
        bus.rd_addr   = '0;
        sbus.wr_start = 1'b0;
        sbus.wr_en    = 1'b0;
        sbus.wr_data  = '0;
        sbus.swap     = 1'b0;
        sbus.rd_en    = 1'b0;
        sbus.rd_addr  = '0;
        prev_v = 1'b0;
        prev_d = '0;
        last_d = '0;

        repeat (2) @(posedge clock);
        #1;
        check("rst_bank_sel", {95'b0, bus.bank_sel}, Z);
        check("rst_active", {88'b0, bus.active_count}, Z);
        check("rst_shadow", {88'b0, bus.shadow_count}, Z);
        check("rst_full", {95'b0, bus.wr_full}, Z);
        check("rst_ovf", {95'b0, bus.wr_overflow}, Z);
        check("rst_rd_valid", {95'b0, bus.rd_valid}, Z);
        check("rst_rd_data", bus.rd_data, Z);
        check("rst_small_full", {95'b0, sbus.wr_full}, Z);
        @(negedge clock);
        rst_n = 1'b1;

        // Empty active bank: count word and particle 1 both read zero.
        rd(8'd0, Z);
        rd(8'd1, Z);
        idle();
        idle();
        check("t1_bank_sel", {95'b0, bus.bank_sel}, Z);
        check("t1_full", {95'b0, bus.wr_full}, Z);

        // Append A,B,C, swap, read 0..4 back to back.
        step(1'b1, 1'b0, Z, 1'b0, 1'b0, 8'd0, Z);
        app(A);
        app(B);
        app(C);
        check("t2_shadow3", {88'b0, bus.shadow_count}, 96'd3);
        step(1'b0, 1'b0, Z, 1'b1, 1'b0, 8'd0, Z);
        check("t2_bank_sel", {95'b0, bus.bank_sel}, 96'd1);
        check("t2_shadow0", {88'b0, bus.shadow_count}, Z);
        check("t2_active", {88'b0, bus.active_count}, 96'd3);
        rd(8'd0, 96'd3);
        rd(8'd1, A);
        rd(8'd2, B);
        rd(8'd3, C);
        rd(8'd4, Z);
        rd(8'd250, Z);
        idle();
        idle();

        // Small instance: capacity 3, fourth append dropped.
        sbus.wr_start = 1'b1;
        idle();
        sbus.wr_start = 1'b0;
        sbus.wr_en    = 1'b1;
        sbus.wr_data  = A;
        idle();
        sbus.wr_data  = B;
        idle();
        check("t3_full_early", {95'b0, sbus.wr_full}, Z);
        sbus.wr_data  = C;
        idle();
        check("t3_count3", {93'b0, sbus.shadow_count}, 96'd3);
        check("t3_full", {95'b0, sbus.wr_full}, 96'd1);
        check("t3_ovf0", {95'b0, sbus.wr_overflow}, Z);
        sbus.wr_data  = D;
        idle();
        check("t3_count_hold", {93'b0, sbus.shadow_count}, 96'd3);
        check("t3_ovf1", {95'b0, sbus.wr_overflow}, 96'd1);
        sbus.wr_en    = 1'b0;
        idle();
        check("t3_ovf_sticky", {95'b0, sbus.wr_overflow}, 96'd1);
        sbus.wr_start = 1'b1;
        idle();
        sbus.wr_start = 1'b0;
        check("t3_ovf_clr", {95'b0, sbus.wr_overflow}, Z);
        check("t3_count_clr", {93'b0, sbus.shadow_count}, Z);
        check("t3_full_clr", {95'b0, sbus.wr_full}, Z);

        // Fill D,E while reading addr 1 every cycle; swap mid-stream.
        step(1'b1, 1'b0, Z, 1'b0, 1'b1, 8'd1, A);
        step(1'b0, 1'b1, D, 1'b0, 1'b1, 8'd1, A);
        step(1'b0, 1'b1, E, 1'b0, 1'b1, 8'd1, A);
        step(1'b0, 1'b0, Z, 1'b1, 1'b1, 8'd1, A);
        check("t4_active", {88'b0, bus.active_count}, 96'd2);
        check("t4_bank_sel", {95'b0, bus.bank_sel}, Z);
        rd(8'd1, D);
        rd(8'd2, E);
        rd(8'd3, Z);
        idle();
        idle();

        // Swap with a same-cycle append: F lands in the new active bank.
        step(1'b1, 1'b0, Z, 1'b0, 1'b0, 8'd0, Z);
        app(D);
        step(1'b0, 1'b1, F, 1'b1, 1'b0, 8'd0, Z);
        check("t5_active", {88'b0, bus.active_count}, 96'd2);
        check("t5_bank_sel", {95'b0, bus.bank_sel}, 96'd1);
        check("t5_shadow", {88'b0, bus.shadow_count}, Z);
        rd(8'd2, F);
        rd(8'd1, D);
        rd(8'd0, 96'd2);
        idle();
        idle();

        // Async reset in the middle of a read burst.
        step(1'b1, 1'b0, Z, 1'b0, 1'b0, 8'd0, Z);
        app(A);
        app(B);
        app(C);
        step(1'b0, 1'b0, Z, 1'b1, 1'b0, 8'd0, Z);
        check("t6_active3", {88'b0, bus.active_count}, 96'd3);
        rd(8'd1, A);
        rd(8'd2, B);
        rd(8'd3, C);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rd_valid", {95'b0, bus.rd_valid}, Z);
        check("t6_rd_data", bus.rd_data, Z);
        check("t6_active0", {88'b0, bus.active_count}, Z);
        check("t6_bank_sel", {95'b0, bus.bank_sel}, Z);
        prev_v = 1'b0;
        last_d = '0;
        bus.rd_en = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
        rd(8'd1, Z);
        idle();
        idle();
        check("t6_active_post", {88'b0, bus.active_count}, Z);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
